shared_reg_arbiter: RTL

Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register among NUM_REQ requesters. Each requester raises a request with write data. The block grants one requester at a time, captures its data into the shared register and acknowledges it. It sits between requester logic and the shared register, and drives the register's capture enable and data select.

---
 rtl/shared_reg_pkg.sv | 20 ++
 rtl/rr_picker.sv | 27 ++
 rtl/shared_reg_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/shared_reg_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
// Optional lock feature is enabled in the top by defining SHARED_REG_LOCK_EN.
package shared_reg_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_IDX_W   = $clog2(DEF_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request at or above the
// pointer, wrapping past the top index back to 0.
module rr_picker
  import shared_reg_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_req
);

  always_comb begin
    int idx;
    o_winner  = '0;
    o_any_req = |i_req;
    // Scan from farthest to nearest so the nearest hit is the one that sticks.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(i_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req[idx]) o_winner = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register: IDLE -> GRANT -> ACK.
// Define SHARED_REG_LOCK_EN to add the lock port (owner may win back-to-back).
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
  input  logic [NUM_REQ-1:0]       lock,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [IDX_W-1:0]         owner
);

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_winner;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic [WIDTH-1:0]     r_q;
  logic                 r_q_valid;
  logic [IDX_W-1:0]     r_owner;

  logic [IDX_W-1:0]     w_winner;
  logic                 w_any_req;
  logic [IDX_W-1:0]     w_next_ptr;
  logic [IDX_W-1:0]     w_rr_next;
  logic [WIDTH-1:0]     w_wdata_sel;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req     (req),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_wdata_sel = wdata[r_winner*WIDTH +: WIDTH];
  assign w_rr_next   = (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;

`ifdef SHARED_REG_LOCK_EN
  assign w_next_ptr = lock[r_winner] ? r_winner : w_rr_next;
`else
  assign w_next_ptr = w_rr_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_winner  <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
    end else begin
      r_gnt <= '0;
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_winner <= w_winner;
            r_gnt    <= ONE_HOT0 << w_winner;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request aborts without touching q or the pointer.
          if (req[r_winner]) begin
            r_q       <= w_wdata_sel;
            r_ack     <= ONE_HOT0 << r_winner;
            r_owner   <= r_winner;
            r_q_valid <= 1'b1;
            r_state   <= ACK;
          end else begin
            r_state <= IDLE;
          end
        end
        ACK: begin
          r_rr_ptr <= w_next_ptr;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign ack     = r_ack;
  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign owner   = r_owner;

endmodule
